// File: rtl/prog_loader_if.sv
// Host/program-memory bundle for prog_loader: byte stream in, word writes and status out.
// master = stream source / supervisor side, slave = the loader itself.
interface prog_loader_if #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 13
);
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              we;
    logic [AWIDTH-1:0] waddr;
    logic [DWIDTH-1:0] wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_rst;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, we, waddr, wdata, busy, done, err, cpu_rst
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, we, waddr, wdata, busy, done, err, cpu_rst
    );
endinterface

// File: rtl/prog_loader.sv
// Loads a count-prefixed byte stream into program memory as DWIDTH-bit words (high byte first).
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module prog_loader #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 13
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_CNT, S_HI, S_LO, S_WR, S_CHK, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_CNT, S_HI, S_LO, S_WR, S_DONE, S_ERR
    } state_t;
`endif

    // A zero count byte means a full address space, capped at 256 words.
    localparam logic [8:0] ZERO_CNT = (AWIDTH >= 8) ? 9'd256 : 9'(1 << AWIDTH);

    state_t            state;
    state_t            state_nxt;
    logic [AWIDTH-1:0] waddr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [8:0]        remain_q;
    logic              hold_q;
    logic              in_ready;
    logic              we;
    logic              busy;
    logic              take;
    logic              start_ok;
    logic [7:0]        hi_spare;
    logic              hi_bad;

    assign take     = in_ready & bus.in_valid;
    assign start_ok = bus.start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
    assign hi_spare = bus.in_data >> (DWIDTH - 8);
    assign hi_bad   = |hi_spare;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= 8'd0;
        end else if (start_ok) begin
            csum_q <= 8'd0;
        end else if (take && ((state == S_HI) || (state == S_LO))) begin
            csum_q <= csum_q + bus.in_data;
        end
    end
`endif

    // NOTE: registers use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Keeps the CPU in reset for the first edge after release even though the FSM sits in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= 1'b1;
        end else begin
            hold_q <= 1'b0;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        we        = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) state_nxt = S_CNT;
            end
            S_CNT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (bus.in_valid) state_nxt = S_HI;
            end
            S_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (bus.in_valid) state_nxt = hi_bad ? S_ERR : S_LO;
            end
            S_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (bus.in_valid) state_nxt = S_WR;
            end
            S_WR: begin
                we   = 1'b1;
                busy = 1'b1;
                if (remain_q == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = S_CHK;
`else
                    state_nxt = S_DONE;
`endif
                end else begin
                    state_nxt = S_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (bus.in_valid) state_nxt = (bus.in_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr_q  <= '0;
            wdata_q  <= '0;
            remain_q <= 9'd0;
        end else begin
            if (start_ok) waddr_q <= '0;
            case (state)
                S_CNT: begin
                    if (take) remain_q <= (bus.in_data == 8'd0) ? ZERO_CNT : {1'b0, bus.in_data};
                end
                S_HI: begin
                    if (take) wdata_q[DWIDTH-1:8] <= bus.in_data[DWIDTH-9:0];
                end
                S_LO: begin
                    if (take) wdata_q[7:0] <= bus.in_data;
                end
                S_WR: begin
                    waddr_q  <= waddr_q + AWIDTH'(1);
                    remain_q <= remain_q - 9'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.we       = we;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign bus.busy     = busy;
    assign bus.done     = (state == S_DONE);
    assign bus.err      = (state == S_ERR);
    assign bus.cpu_rst  = hold_q | busy;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader; a stream-parsing reference model predicts writes and status.
// Honours LOADER_CHECKSUM_EN the same way as the design.
`timescale 1ns/1ps
module tb_prog_loader;
    localparam int AWIDTH = 8;
    localparam int DWIDTH = 13;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_loader_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) lif ();
    prog_loader #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (.clk(clk), .rst(rst), .bus(lif));

    int checks = 0;
    int errors = 0;

    logic [7:0] stream[$];
    int         exp_w[$];
    int         obs_w[$];
    bit         exp_err;
    int         exp_used;

    // Each write is recorded as (addr << 16) | data.
    always @(negedge clk) begin
        if (lif.we === 1'b1) obs_w.push_back((int'(lif.waddr) << 16) | int'(lif.wdata));
    end

    // Parse the stream the way a host-side loader description reads it.
    task automatic model();
        int n, i, addr, hi, lo, sum;
        exp_w.delete();
        exp_err = 1'b0;
        n = (stream[0] == 8'd0) ? 256 : int'(stream[0]);
        i = 1; addr = 0; sum = 0;
        for (int w = 0; w < n; w++) begin
            hi = int'(stream[i]); i++;
            sum = (sum + hi) % 256;
            if (hi >= (1 << (DWIDTH - 8))) begin
                exp_err = 1'b1;
                break;
            end
            lo = int'(stream[i]); i++;
            sum = (sum + lo) % 256;
            exp_w.push_back((addr << 16) | (hi * 256 + lo));
            addr = (addr + 1) % (1 << AWIDTH);
        end
        if (CSUM && !exp_err) begin
            if (int'(stream[i]) != sum) exp_err = 1'b1;
            i++;
        end
        exp_used = i;
    endtask

    task automatic gen_stream(input int n, input int bad_at, input bit bad_csum);
        int nn, sum, hi, lo;
        stream.delete();
        stream.push_back(8'(n));
        nn = (n == 0) ? 256 : n;
        sum = 0;
        for (int w = 0; w < nn; w++) begin
            if (w == bad_at) begin
                stream.push_back(8'($urandom_range(32, 255)));
                return;
            end
            hi = $urandom_range(0, 31);
            lo = $urandom_range(0, 255);
            stream.push_back(8'(hi));
            stream.push_back(8'(lo));
            sum = sum + hi + lo;
        end
        if (CSUM) stream.push_back(8'(sum + int'(bad_csum)));
    endtask

    task automatic set_directed();
        stream = '{8'h02, 8'h01, 8'hAE, 8'h0C, 8'h04};
        if (CSUM) stream.push_back(8'hBF);
    endtask

    task automatic do_start();
        lif.start = 1'b1;
        @(posedge clk); #1;
        lif.start = 1'b0;
    endtask

    // mode 0: valid held, 1: valid toggles, 2: random gaps. A start pulse is fired mid-load.
    task automatic drive(input int mode, input int pulse_at, output int cyc);
        int idx;
        bit v, taken;
        idx = 0; cyc = 0;
        while (idx < stream.size() && cyc < 5000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            lif.in_valid = v;
            lif.in_data  = v ? stream[idx] : 8'($urandom);
            lif.start    = (cyc == pulse_at);
            @(negedge clk);
            taken = (lif.in_valid === 1'b1) && (lif.in_ready === 1'b1);
            @(posedge clk); #1;
            if (taken) idx++;
            cyc++;
        end
        lif.in_valid = 1'b0;
        lif.start    = 1'b0;
        checks++;
        if (idx != stream.size()) begin
            errors++;
            $display("FAIL bytes_consumed: got %0d need %0d", idx, stream.size());
        end
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (lif.busy === 1'b1 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (lif.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles", lif.busy, cyc);
        end
    endtask

    task automatic run_load(input int mode, input int pulse_at, output int cyc);
        int c1, c2;
        obs_w.delete();
        model();
        do_start();
        drive(mode, pulse_at, c1);
        wait_idle(c2);
        cyc = c1 + c2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({lif.in_ready, lif.we, lif.busy, lif.done, lif.err, lif.cpu_rst} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_flags: got %b need 000001",
                     {lif.in_ready, lif.we, lif.busy, lif.done, lif.err, lif.cpu_rst});
        end
        checks++;
        if ({lif.waddr, lif.wdata} !== '0) begin
            errors++;
            $display("FAIL reset_bus: waddr=%h wdata=%h need 0", lif.waddr, lif.wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (lif.cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL cpu_rst_before_edge: got %b need 1", lif.cpu_rst);
        end
        @(posedge clk); #1;
        checks++;
        if ({lif.cpu_rst, lif.busy} !== 2'b00) begin
            errors++;
            $display("FAIL cpu_rst_release: cpu_rst,busy=%b need 00", {lif.cpu_rst, lif.busy});
        end
    endtask

    task automatic check_directed(input string tag, input int cyc, input bit check_cyc);
        checks++;
        if (obs_w.size() != 2 || obs_w[0] != 32'h0000_01AE || obs_w[1] != 32'h0001_0C04) begin
            errors++;
            $display("FAIL %s_writes: got %0d writes [%h %h] need [000001ae 00010c04]", tag,
                     obs_w.size(), (obs_w.size() > 0) ? obs_w[0] : -1, (obs_w.size() > 1) ? obs_w[1] : -1);
        end
        checks++;
        if ({lif.done, lif.err, lif.busy, lif.cpu_rst} !== 4'b1000) begin
            errors++;
            $display("FAIL %s_status: done,err,busy,cpu_rst=%b need 1000", tag,
                     {lif.done, lif.err, lif.busy, lif.cpu_rst});
        end
        if (check_cyc) begin
            checks++;
            if (cyc != 7 + int'(CSUM)) begin
                errors++;
                $display("FAIL %s_latency: got %0d cycles need %0d", tag, cyc, 7 + int'(CSUM));
            end
        end
    endtask

    task automatic test_directed();
        int cyc;
        set_directed();
        run_load(0, -1, cyc);
        check_directed("directed", cyc, 1'b1);
    endtask

    task automatic test_backpressure();
        int cyc;
        set_directed();
        run_load(1, 3, cyc);
        check_directed("backpressure", cyc, 1'b0);
    endtask

    task automatic test_bad_high();
        int cyc;
        stream = '{8'h01, 8'h21};
        run_load(0, -1, cyc);
        checks++;
        if ({lif.err, lif.done, lif.busy, lif.cpu_rst} !== 4'b1000 || obs_w.size() != 0) begin
            errors++;
            $display("FAIL bad_high: err,done,busy,cpu_rst=%b writes=%0d need 1000 and 0",
                     {lif.err, lif.done, lif.busy, lif.cpu_rst}, obs_w.size());
        end
        do_start();
        checks++;
        if ({lif.err, lif.busy} !== 2'b01 || lif.waddr !== 8'h00) begin
            errors++;
            $display("FAIL restart: err,busy=%b waddr=%h need 01 and 00", {lif.err, lif.busy}, lif.waddr);
        end
        set_directed();
        obs_w.delete();
        drive(2, -1, cyc);
        wait_idle(cyc);
        check_directed("after_err", cyc, 1'b0);
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int cyc;
        stream = '{8'h01, 8'h00, 8'h11, 8'h11};
        run_load(0, -1, cyc);
        checks++;
        if ({lif.done, lif.err} !== 2'b10 || obs_w.size() != 1 || obs_w[0] != 32'h0000_0011) begin
            errors++;
            $display("FAIL csum_good: done,err=%b writes=%0d need 10 and 1", {lif.done, lif.err}, obs_w.size());
        end
        stream = '{8'h01, 8'h00, 8'h11, 8'h12};
        run_load(0, -1, cyc);
        checks++;
        if ({lif.done, lif.err} !== 2'b01 || obs_w.size() != 1 || obs_w[0] != 32'h0000_0011) begin
            errors++;
            $display("FAIL csum_bad: done,err=%b writes=%0d need 01 and 1", {lif.done, lif.err}, obs_w.size());
        end
    endtask
`endif

    task automatic test_random_loads();
        int cyc, n, bad_at, mism;
        for (int it = 0; it < 24; it++) begin
            n = $urandom_range(1, 6);
            bad_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            gen_stream(n, bad_at, ($urandom_range(0, 3) == 0));
            run_load(it % 3, $urandom_range(0, 6), cyc);
            mism = 0;
            for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) begin
                if (obs_w[k] != exp_w[k]) mism++;
            end
            checks++;
            if (obs_w.size() != exp_w.size() || mism != 0) begin
                errors++;
                $display("FAIL random_writes[%0d]: got %0d writes (%0d differ) need %0d", it,
                         obs_w.size(), mism, exp_w.size());
            end
            checks++;
            if ({lif.done, lif.err} !== {~exp_err, exp_err}) begin
                errors++;
                $display("FAIL random_status[%0d]: done,err=%b need %b", it, {lif.done, lif.err}, {~exp_err, exp_err});
            end
        end
    endtask

    task automatic test_full_256();
        int cyc, mism;
        gen_stream(0, -1, 1'b0);
        run_load(0, -1, cyc);
        mism = 0;
        for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) begin
            if (obs_w[k] != exp_w[k]) mism++;
        end
        checks++;
        if (obs_w.size() != 256 || mism != 0 || (obs_w[255] >> 16) != 255) begin
            errors++;
            $display("FAIL full_writes: got %0d writes (%0d differ) need 256 ending at addr ff", obs_w.size(), mism);
        end
        checks++;
        if ({lif.done, lif.busy} !== 2'b10 || lif.waddr !== 8'h00) begin
            errors++;
            $display("FAIL full_status: done,busy=%b waddr=%h need 10 and 00", {lif.done, lif.busy}, lif.waddr);
        end
    endtask

    task automatic test_reset_midload();
        int cyc;
        stream = '{8'h02, 8'h01};
        obs_w.delete();
        do_start();
        drive(0, -1, cyc);
        checks++;
        if ({lif.in_ready, lif.busy, lif.we} !== 3'b110) begin
            errors++;
            $display("FAIL midload_in_lo: in_ready,busy,we=%b need 110", {lif.in_ready, lif.busy, lif.we});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({lif.in_ready, lif.we, lif.busy, lif.done, lif.err, lif.cpu_rst} !== 6'b000001 ||
            {lif.waddr, lif.wdata} !== '0) begin
            errors++;
            $display("FAIL midload_async: flags=%b waddr=%h wdata=%h need 000001 0 0",
                     {lif.in_ready, lif.we, lif.busy, lif.done, lif.err, lif.cpu_rst}, lif.waddr, lif.wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        obs_w.delete();
        lif.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            lif.in_data = 8'($urandom);
            @(posedge clk); #1;
        end
        lif.in_valid = 1'b0;
        checks++;
        if (obs_w.size() != 0 || {lif.busy, lif.done, lif.err, lif.cpu_rst, lif.in_ready} !== 5'b00000) begin
            errors++;
            $display("FAIL midload_after: writes=%0d busy,done,err,cpu_rst,in_ready=%b need 0 and 00000",
                     obs_w.size(), {lif.busy, lif.done, lif.err, lif.cpu_rst, lif.in_ready});
        end
    endtask

    initial begin
        lif.start    = 1'b0;
        lif.in_valid = 1'b0;
        lif.in_data  = 8'h00;
        test_reset();
        test_directed();
        test_backpressure();
        test_bad_high();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_random_loads();
        test_full_256();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
